uart_rx_loader: RTL

UART receiver and program loader on the board's `UART_RXD` pin, the receive end of the serial link whose transmit side leaves on `UART_TXD`. It deserialises 8N1 frames, reports each byte, and packs every four bytes, little-endian, into a 32-bit word with a write strobe and a word-aligned byte address. The core uses this to fill instruction/data memory from a host PC without resynthesis. It runs on the same clock as the memories it writes.

---
 rtl/uart_rx_loader_pkg.sv | 12 +
 rtl/uart_rx_loader_rx_sync.sv | 20 ++
 rtl/uart_rx_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_loader_pkg.sv
// uart_rx_loader_pkg: receiver FSM states and default baud constants,
// shared so a future transmitter can use the same encodings.
package uart_rx_loader_pkg;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} uart_state_t;

    localparam int CLK_HZ           = 50_000_000;
    localparam int BAUD             = 115_200;
    localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int DEF_TIMEOUT_BITS = 32;

endpackage

// File: rtl/uart_rx_loader_rx_sync.sv
// rx_sync: two-flop synchroniser for an asynchronous input, resetting to RST_VAL.
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s_q <= {2{RST_VAL}};
        else      s_q <= {s_q[0], d};
    end

    assign q = s_q[1];

endmodule

// File: rtl/uart_rx_loader.sv
// uart_rx_loader: 8N1 UART receiver that packs bytes little-endian into
// 32-bit word writes at consecutive word-aligned addresses.
module uart_rx_loader
    import uart_rx_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = 32,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              en,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              word_we,
    output logic [ADDR_W-1:0] word_addr,
    output logic [31:0]       word_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_CYC);

    uart_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [TW-1:0]     to_q, to_d;
    logic [7:0]        bd_q, bd_d;
    logic              bv_q, bv_d, we_q, we_d, fe_q, fe_d;
    logic              rxs, tick;

    rx_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));

    assign tick = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = we_q ? 2'd0 : idx_q;
        addr_d  = we_q ? addr_q + ADDR_W'(4) : addr_q;
        word_d  = word_q;
        to_d    = '0;
        bd_d    = bd_q;
        bv_d    = 1'b0;
        we_d    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // a partial word left idle too long is abandoned
                if (idx_q != 2'd0) begin
                    to_d = to_q + 1'b1;
                    if (to_q == TW'(TO_CYC - 1)) begin
                        idx_d = 2'd0;
                        to_d  = '0;
                    end
                end
                if (!rxs && en) begin
                    state_d = S_START;
                    cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
                end
            end
            S_START: if (tick) begin
                state_d = rxs ? S_IDLE : S_DATA;
                cnt_d   = CW'(CLKS_PER_BIT - 1);
                bit_d   = 3'd0;
            end
            S_DATA: if (tick) begin
                shift_d = {rxs, shift_q[7:1]};
                cnt_d   = CW'(CLKS_PER_BIT - 1);
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
            end
            S_STOP: if (tick) begin
                state_d = rxs ? S_IDLE : S_BREAK;
                fe_d    = !rxs;
                if (rxs) begin
                    bv_d                  = 1'b1;
                    bd_d                  = shift_q;
                    word_d[8*idx_q +: 8]  = shift_q;
                    we_d                  = idx_q == 2'd3;
                    idx_d                 = idx_q == 2'd3 ? idx_q : idx_q + 2'd1;
                end
            end
            S_BREAK: state_d = rxs ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            addr_d  = '0;
            word_d  = '0;
            to_d    = '0;
            bd_d    = '0;
            bv_d    = 1'b0;
            we_d    = 1'b0;
            fe_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            to_q    <= '0;
            bd_q    <= '0;
            bv_q    <= 1'b0;
            we_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            to_q    <= to_d;
            bd_q    <= bd_d;
            bv_q    <= bv_d;
            we_q    <= we_d;
            fe_q    <= fe_d;
        end
    end

    assign byte_valid = bv_q;
    assign byte_data  = bd_q;
    assign word_we    = we_q;
    assign word_addr  = addr_q;
    assign word_data  = word_q;
    assign frame_err  = fe_q;
    assign busy       = state_q != S_IDLE;

endmodule
